// File: rtl/axis_keep_unpacker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_keep_unpacker: wide AXIS beat -> narrow lanes, null lanes skipped.   |
// | Optional: AXIS_KEEP_UNPACKER_ERR_EN adds the sticky err_sparse output.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module axis_keep_unpacker #(
    parameter int AXIS_I_BYTES = 4,
    parameter int AXIS_O_BYTES = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                        clk,
    input  logic                        areset,
    output logic                        axis_i_tready,
    input  logic                        axis_i_tvalid,
    input  logic                        axis_i_tlast,
    input  logic [AXIS_I_BYTES*8-1:0]   axis_i_tdata,
    input  logic [AXIS_I_BYTES-1:0]     axis_i_tkeep,
    input  logic                        axis_o_tready,
    output logic                        axis_o_tvalid,
    output logic                        axis_o_tlast,
    output logic [AXIS_O_BYTES*8-1:0]   axis_o_tdata,
    output logic [AXIS_O_BYTES-1:0]     axis_o_tkeep
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
    ,
    output logic                        err_sparse
`endif
);

    localparam int NLANES     = AXIS_I_BYTES / AXIS_O_BYTES;
    localparam int CW         = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int LW         = AXIS_O_BYTES * 8;
    localparam int FIRST_LANE = (MSB_FIRST != 0) ? NLANES - 1 : 0;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_OUTPUT = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [AXIS_I_BYTES*8-1:0] data_q,  data_d;
    logic [AXIS_I_BYTES-1:0]   keep_q,  keep_d;
    logic [NLANES-1:0]         mask_q,  mask_d;
    logic                      last_q,  last_d;
    logic [CW-1:0]             ctr_q,   ctr_d;

    logic [NLANES-1:0]         in_mask;
    logic [NLANES-1:0]         load_mask;
    logic [CW-1:0]             first_lane;
    logic                      first_found;
    logic [CW-1:0]             next_lane;
    logic                      has_next;
    logic                      past_ctr;
    logic                      in_hs;
    logic                      out_hs;

    // Lane index occupying position pos of the emission order.
    function automatic int lane_at(input int pos);
        return (MSB_FIRST != 0) ? (NLANES - 1 - pos) : pos;
    endfunction

    generate
        for (genvar k = 0; k < NLANES; k++) begin : g_lane_mask
            assign in_mask[k] = |axis_i_tkeep[k*AXIS_O_BYTES +: AXIS_O_BYTES];
        end
    endgenerate

    // An all-null beat carrying tlast still needs a carrier lane for the packet end.
    always_comb begin
        load_mask = in_mask;
        if ((in_mask == '0) && axis_i_tlast) begin
            load_mask[FIRST_LANE] = 1'b1;
        end
    end

    always_comb begin
        first_lane  = CW'(FIRST_LANE);
        first_found = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            if (!first_found && load_mask[lane_at(i)]) begin
                first_lane  = CW'(lane_at(i));
                first_found = 1'b1;
            end
        end
    end

    always_comb begin
        next_lane = ctr_q;
        has_next  = 1'b0;
        past_ctr  = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            if (past_ctr && !has_next && mask_q[lane_at(i)]) begin
                next_lane = CW'(lane_at(i));
                has_next  = 1'b1;
            end
            if (ctr_q == CW'(lane_at(i))) begin
                past_ctr = 1'b1;
            end
        end
    end

    always_comb begin
        axis_o_tdata = '0;
        axis_o_tkeep = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (ctr_q == CW'(k)) begin
                axis_o_tdata = data_q[k*LW +: LW];
                axis_o_tkeep = keep_q[k*AXIS_O_BYTES +: AXIS_O_BYTES];
            end
        end
    end

    assign axis_o_tvalid = (state_q == ST_OUTPUT);
    assign axis_o_tlast  = axis_o_tvalid && last_q && !has_next;

    // Ready when idle, or when the final lane drains this cycle.
    assign axis_i_tready = !areset &&
                           ((state_q == ST_EMPTY) ||
                            ((state_q == ST_OUTPUT) && !has_next && axis_o_tready));

    assign in_hs  = axis_i_tvalid && axis_i_tready;
    assign out_hs = axis_o_tvalid && axis_o_tready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        mask_d  = mask_q;
        last_d  = last_q;
        ctr_d   = ctr_q;
        if (out_hs) begin
            if (has_next) begin
                ctr_d = next_lane;
            end else begin
                state_d = ST_EMPTY;
            end
        end
        if (in_hs && (load_mask != '0)) begin
            data_d  = axis_i_tdata;
            keep_d  = axis_i_tkeep;
            mask_d  = load_mask;
            last_d  = axis_i_tlast;
            ctr_d   = first_lane;
            state_d = ST_OUTPUT;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            ctr_q   <= ctr_d;
        end
    end

`ifdef AXIS_KEEP_UNPACKER_ERR_EN
    logic hole;
    logic seen_null;
    logic err_q;

    // A hole is a null lane followed later in emission order by a valid lane.
    always_comb begin
        hole      = 1'b0;
        seen_null = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            if (in_mask[lane_at(i)]) begin
                if (seen_null) begin
                    hole = 1'b1;
                end
            end else begin
                seen_null = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err_q <= 1'b0;
        end else if (in_hs && hole) begin
            err_q <= 1'b1;
        end
    end

    assign err_sparse = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_keep_unpacker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_keep_unpacker: directed self-checking bench, LSB- and MSB-first.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_axis_keep_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;

    logic        a_itready, a_itvalid, a_itlast;
    logic [31:0] a_itdata;
    logic [3:0]  a_itkeep;
    logic        a_otready, a_otvalid, a_otlast;
    logic [7:0]  a_otdata;
    logic [0:0]  a_otkeep;

    logic        b_itready, b_itvalid, b_itlast;
    logic [31:0] b_itdata;
    logic [3:0]  b_itkeep;
    logic        b_otready, b_otvalid, b_otlast;
    logic [7:0]  b_otdata;
    logic [0:0]  b_otkeep;

`ifdef AXIS_KEEP_UNPACKER_ERR_EN
    logic        a_err, b_err;
`endif

    int checks   = 0;
    int failures = 0;

    axis_keep_unpacker #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(0)) dut (
        .clk(clk), .areset(areset),
        .axis_i_tready(a_itready), .axis_i_tvalid(a_itvalid), .axis_i_tlast(a_itlast),
        .axis_i_tdata(a_itdata), .axis_i_tkeep(a_itkeep),
        .axis_o_tready(a_otready), .axis_o_tvalid(a_otvalid), .axis_o_tlast(a_otlast),
        .axis_o_tdata(a_otdata), .axis_o_tkeep(a_otkeep)
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
        , .err_sparse(a_err)
`endif
    );

    axis_keep_unpacker #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .areset(areset),
        .axis_i_tready(b_itready), .axis_i_tvalid(b_itvalid), .axis_i_tlast(b_itlast),
        .axis_i_tdata(b_itdata), .axis_i_tkeep(b_itkeep),
        .axis_o_tready(b_otready), .axis_o_tvalid(b_otvalid), .axis_o_tlast(b_otlast),
        .axis_o_tdata(b_otdata), .axis_o_tkeep(b_otkeep)
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
        , .err_sparse(b_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic valid, input logic [7:0] data,
                           input logic [0:0] keep, input logic last,
                           input logic [7:0] exp_data, input logic [0:0] exp_keep,
                           input logic exp_last);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, data},  {24'd0, exp_data});
        chk({tag, "_keep"},  {31'd0, keep},  {31'd0, exp_keep});
        chk({tag, "_last"},  {31'd0, last},  {31'd0, exp_last});
    endtask

    task automatic drive_a(input logic [31:0] d, input logic [3:0] k, input logic l);
        a_itdata  = d;
        a_itkeep  = k;
        a_itlast  = l;
        a_itvalid = 1'b1;
    endtask

    initial begin
        areset    = 1'b1;
        a_itvalid = 1'b0; a_itlast = 1'b0; a_itdata = '0; a_itkeep = '0; a_otready = 1'b1;
        b_itvalid = 1'b0; b_itlast = 1'b0; b_itdata = '0; b_itkeep = '0; b_otready = 1'b1;
        #2;
        chk("rst_ovalid",  {31'd0, a_otvalid}, 32'd0);
        chk("rst_olast",   {31'd0, a_otlast},  32'd0);
        chk("rst_odata",   {24'd0, a_otdata},  32'd0);
        chk("rst_okeep",   {31'd0, a_otkeep},  32'd0);
        chk("rst_itready", {31'd0, a_itready}, 32'd0);
        tick();
        tick();
        areset = 1'b0;
        #1;
        chk("post_rst_itready", {31'd0, a_itready}, 32'd1);
        chk("post_rst_ovalid",  {31'd0, a_otvalid}, 32'd0);

        // Full beat, LSB first.
        drive_a(32'h44332211, 4'hF, 1'b1);
        tick(); a_itvalid = 1'b0;
        chk_out("t1_l0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h11, 1'b1, 1'b0); tick();
        chk_out("t1_l1", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h22, 1'b1, 1'b0); tick();
        chk_out("t1_l2", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h33, 1'b1, 1'b0); tick();
        chk_out("t1_l3", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h44, 1'b1, 1'b1); tick();
        chk("t1_idle", {31'd0, a_otvalid}, 32'd0);

        // Short packet end: keep=0x3.
        drive_a(32'h44332211, 4'h3, 1'b1);
        tick(); a_itvalid = 1'b0;
        chk_out("t2_l0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h11, 1'b1, 1'b0);
        chk("t2_itready_l0", {31'd0, a_itready}, 32'd0);
        tick();
        chk_out("t2_l1", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h22, 1'b1, 1'b1);
        chk("t2_itready_l1", {31'd0, a_itready}, 32'd1);
        tick();
        chk("t2_idle", {31'd0, a_otvalid}, 32'd0);

        // Back-to-back beats with no bubble.
        drive_a(32'h44332211, 4'hF, 1'b0);
        tick();
        drive_a(32'h88776655, 4'hF, 1'b1);
        chk_out("t3_a0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h11, 1'b1, 1'b0); tick();
        chk_out("t3_a1", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h22, 1'b1, 1'b0); tick();
        chk_out("t3_a2", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h33, 1'b1, 1'b0); tick();
        chk_out("t3_a3", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h44, 1'b1, 1'b0);
        chk("t3_itready_a3", {31'd0, a_itready}, 32'd1);
        tick(); a_itvalid = 1'b0;
        chk_out("t3_b0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h55, 1'b1, 1'b0); tick();
        chk_out("t3_b1", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h66, 1'b1, 1'b0); tick();
        chk_out("t3_b2", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h77, 1'b1, 1'b0); tick();
        chk_out("t3_b3", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h88, 1'b1, 1'b1); tick();
        chk("t3_idle", {31'd0, a_otvalid}, 32'd0);

        // Output stalls hold data and preserve order.
        drive_a(32'hDDCCBBAA, 4'hF, 1'b1);
        a_otready = 1'b0;
        tick(); a_itvalid = 1'b0;
        chk_out("t4_s0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hAA, 1'b1, 1'b0); tick();
        chk_out("t4_s0h", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hAA, 1'b1, 1'b0);
        a_otready = 1'b1; tick();
        chk_out("t4_s1", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hBB, 1'b1, 1'b0);
        a_otready = 1'b0; tick(); tick();
        chk_out("t4_s1h", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hBB, 1'b1, 1'b0);
        a_otready = 1'b1; tick();
        chk_out("t4_s2", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hCC, 1'b1, 1'b0); tick();
        chk_out("t4_s3", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hDD, 1'b1, 1'b1); tick();
        chk("t4_idle", {31'd0, a_otvalid}, 32'd0);

        // Null beats.
        drive_a(32'h12345678, 4'h0, 1'b0);
        #1;
        chk("t5_null_itready", {31'd0, a_itready}, 32'd1);
        tick(); a_itvalid = 1'b0;
        chk("t5_null_novalid0", {31'd0, a_otvalid}, 32'd0);
        tick();
        chk("t5_null_novalid1", {31'd0, a_otvalid}, 32'd0);
        drive_a(32'hAABBCCDD, 4'h0, 1'b1);
        tick(); a_itvalid = 1'b0;
        chk_out("t5_nulllast", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'hDD, 1'b0, 1'b1); tick();
        chk("t5_idle", {31'd0, a_otvalid}, 32'd0);
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
        chk("t5_err_clear", {31'd0, a_err}, 32'd0);
`endif

        // Hole: keep=0x5 skips lane 1.
        drive_a(32'h44332211, 4'h5, 1'b1);
        tick(); a_itvalid = 1'b0;
        chk_out("t6_l0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h11, 1'b1, 1'b0);
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
        chk("t6_err_set", {31'd0, a_err}, 32'd1);
`endif
        tick();
        chk_out("t6_l2", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h33, 1'b1, 1'b1); tick();
        chk("t6_idle", {31'd0, a_otvalid}, 32'd0);

        // MSB-first instance.
        b_itdata = 32'h44332211; b_itkeep = 4'hC; b_itlast = 1'b1; b_itvalid = 1'b1;
        tick(); b_itvalid = 1'b0;
        chk_out("t7_m0", b_otvalid, b_otdata, b_otkeep, b_otlast, 8'h44, 1'b1, 1'b0); tick();
        chk_out("t7_m1", b_otvalid, b_otdata, b_otkeep, b_otlast, 8'h33, 1'b1, 1'b1); tick();
        chk("t7_idle", {31'd0, b_otvalid}, 32'd0);
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
        chk("t7_err_none", {31'd0, b_err}, 32'd0);
`endif

        // Reset in the middle of a packet.
        drive_a(32'h44332211, 4'hF, 1'b1);
        tick(); a_itvalid = 1'b0;
        chk_out("t8_l0", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h11, 1'b1, 1'b0); tick();
        chk_out("t8_l1", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h22, 1'b1, 1'b0); tick();
        chk_out("t8_l2", a_otvalid, a_otdata, a_otkeep, a_otlast, 8'h33, 1'b1, 1'b0);
        #1 areset = 1'b1;
        #1;
        chk("t8_rst_ovalid",  {31'd0, a_otvalid}, 32'd0);
        chk("t8_rst_itready", {31'd0, a_itready}, 32'd0);
        chk("t8_rst_odata",   {24'd0, a_otdata},  32'd0);
        chk("t8_rst_olast",   {31'd0, a_otlast},  32'd0);
        tick();
        areset = 1'b0;
        #1;
        chk("t8_rel_itready", {31'd0, a_itready}, 32'd1);
        chk("t8_rel_ovalid0", {31'd0, a_otvalid}, 32'd0);
        tick();
        chk("t8_rel_ovalid1", {31'd0, a_otvalid}, 32'd0);
        tick();
        chk("t8_rel_ovalid2", {31'd0, a_otvalid}, 32'd0);
`ifdef AXIS_KEEP_UNPACKER_ERR_EN
        chk("t8_err_cleared", {31'd0, a_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
